// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter and sequencer placing two core memory
// ports onto the single external-SRAM controller port. The granted command is
// latched for the whole transaction, and a hung controller is detected by a
// per-transaction timeout.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   p0_rd/p0_wr/p0_addr/p0_wd   core0 request (level, held while p0_stall high)
//   p0_stall                core0 must hold its request (combinational)
//   p1_*                    same for core1
//   sram_re/sram_we         registered command strobes to the controller
//   sram_addr/sram_wd       latched address / write data
//   sram_ack                one-cycle completion pulse from the controller
//   grant                   one-hot owner {p1,p0}, 00 when idle (registered)
//   timeout_err             sticky hang flag, cleared only by reset
module sram_port_arbiter #(
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_rd,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wd,
    output logic              p0_stall,
    input  logic              p1_rd,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wd,
    output logic              p1_stall,
    output logic              sram_re,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wd,
    input  logic              sram_ack,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int unsigned      CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           state;
    logic             last;     // last-served port: 0 = p0, 1 = p1
    logic [CNT_W-1:0] cnt;

    logic p0_req;
    logic p1_req;
    logic busy;
    logic done;
    logic abort;
    logic take0;
    logic take1;
    logic to_idle;

    assign p0_req = p0_rd | p0_wr;
    assign p1_req = p1_rd | p1_wr;

    // Stalls release only in the owner's ack cycle; ack in IDLE is ignored.
    assign p0_stall = p0_req & ~((state == BUSY0) & sram_ack);
    assign p1_stall = p1_req & ~((state == BUSY1) & sram_ack);

    assign busy  = (state != IDLE);
    assign done  = busy & sram_ack;
    assign abort = busy & ~sram_ack & (cnt == CNT_MAX);

    // From IDLE a tie goes to the port that was not served last; on an ack
    // edge only the other port may be granted, so the finishing port cannot
    // immediately win again.
    assign take0 = ((state == IDLE)  & p0_req & (~p1_req | last))
                 | ((state == BUSY1) & sram_ack & p0_req);
    assign take1 = ((state == IDLE)  & p1_req & (~p0_req | ~last))
                 | ((state == BUSY0) & sram_ack & p1_req);

    assign to_idle = (done & ~take0 & ~take1) | abort;

    // State, command latch, timeout counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            cnt         <= '0;
            sram_re     <= 1'b0;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wd     <= '0;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
        end else if (take0) begin
            state     <= BUSY0;
            last      <= 1'b0;
            cnt       <= '0;
            sram_we   <= p0_wr;
            sram_re   <= p0_rd & ~p0_wr;
            sram_addr <= p0_addr;
            sram_wd   <= p0_wd;
            grant     <= 2'b01;
        end else if (take1) begin
            state     <= BUSY1;
            last      <= 1'b1;
            cnt       <= '0;
            sram_we   <= p1_wr;
            sram_re   <= p1_rd & ~p1_wr;
            sram_addr <= p1_addr;
            sram_wd   <= p1_wd;
            grant     <= 2'b10;
        end else if (to_idle) begin
            // Address and data are left as they were; only the strobes drop.
            state   <= IDLE;
            cnt     <= '0;
            sram_re <= 1'b0;
            sram_we <= 1'b0;
            grant   <= 2'b00;
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end else if (busy) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              p0_rd, p0_wr, p1_rd, p1_wr;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wd, p1_wd;
    logic              p0_stall, p1_stall;
    logic              sram_re, sram_we, sram_ack;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wd;
    logic [1:0]        grant;
    logic              timeout_err;

    sram_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p0_rd      (p0_rd),
        .p0_wr      (p0_wr),
        .p0_addr    (p0_addr),
        .p0_wd      (p0_wd),
        .p0_stall   (p0_stall),
        .p1_rd      (p1_rd),
        .p1_wr      (p1_wr),
        .p1_addr    (p1_addr),
        .p1_wd      (p1_wd),
        .p1_stall   (p1_stall),
        .sram_re    (sram_re),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wd    (sram_wd),
        .sram_ack   (sram_ack),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs held for one cycle plus outputs expected in that cycle.
    typedef struct {
        logic              rst;
        logic              p0_rd, p0_wr;
        logic [ADDR_W-1:0] p0_addr;
        logic [DATA_W-1:0] p0_wd;
        logic              p1_rd, p1_wr;
        logic [ADDR_W-1:0] p1_addr;
        logic [DATA_W-1:0] p1_wd;
        logic              ack;
        logic              e_re, e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        logic [1:0]        e_grant;
        logic              e_s0, e_s1, e_err;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] W1 = 32'h11111111;
    localparam logic [31:0] WA = 32'hA0A0A0A0;

    function automatic void add(
        input logic rst,
        input logic a0r, input logic a0w, input logic [31:0] a0a, input logic [31:0] a0d,
        input logic a1r, input logic a1w, input logic [31:0] a1a, input logic [31:0] a1d,
        input logic ack,
        input logic ere, input logic ewe, input logic [31:0] ea, input logic [31:0] ed,
        input logic [1:0] eg, input logic es0, input logic es1, input logic eerr);
        vec_t v;
        v.rst = rst;
        v.p0_rd = a0r; v.p0_wr = a0w; v.p0_addr = ADDR_W'(a0a); v.p0_wd = a0d;
        v.p1_rd = a1r; v.p1_wr = a1w; v.p1_addr = ADDR_W'(a1a); v.p1_wd = a1d;
        v.ack = ack;
        v.e_re = ere; v.e_we = ewe; v.e_addr = ADDR_W'(ea); v.e_wd = ed;
        v.e_grant = eg; v.e_s0 = es0; v.e_s1 = es1; v.e_err = eerr;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        reset = v.rst;
        p0_rd = v.p0_rd; p0_wr = v.p0_wr; p0_addr = v.p0_addr; p0_wd = v.p0_wd;
        p1_rd = v.p1_rd; p1_wr = v.p1_wr; p1_addr = v.p1_addr; p1_wd = v.p1_wd;
        sram_ack = v.ack;
        @(negedge clk);
        chk($sformatf("v%0d sram_re", idx),     32'(sram_re),     32'(v.e_re));
        chk($sformatf("v%0d sram_we", idx),     32'(sram_we),     32'(v.e_we));
        chk($sformatf("v%0d sram_addr", idx),   32'(sram_addr),   32'(v.e_addr));
        chk($sformatf("v%0d sram_wd", idx),     sram_wd,          v.e_wd);
        chk($sformatf("v%0d grant", idx),       32'(grant),       32'(v.e_grant));
        chk($sformatf("v%0d p0_stall", idx),    32'(p0_stall),    32'(v.e_s0));
        chk($sformatf("v%0d p1_stall", idx),    32'(p1_stall),    32'(v.e_s1));
        chk($sformatf("v%0d timeout_err", idx), 32'(timeout_err), 32'(v.e_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        p0_rd = 1'b0; p0_wr = 1'b0; p0_addr = '0; p0_wd = '0;
        p1_rd = 1'b0; p1_wr = 1'b0; p1_addr = '0; p1_wd = '0;
        sram_ack = 1'b0;

        // P0 read @0x10, ack on the 4th strobe cycle (also the last cycle before timeout)
        add(1, 0,0,0,0,      0,0,0,0, 0, 0,0,0,0,      2'b00, 0,0,0);
        add(1, 1,0,'h10,0,   0,0,0,0, 0, 0,0,0,0,      2'b00, 1,0,0);
        add(0, 1,0,'h10,0,   0,0,0,0, 0, 0,0,0,0,      2'b00, 1,0,0);
        for (int k = 0; k < 3; k++)
            add(0, 1,0,'h10,0, 0,0,0,0, 0, 1,0,'h10,0, 2'b01, 1,0,0);
        add(0, 1,0,'h10,0,   0,0,0,0, 1, 1,0,'h10,0,   2'b01, 0,0,0);
        add(0, 0,0,0,0,      0,0,0,0, 0, 0,0,'h10,0,   2'b00, 0,0,0);

        // Simultaneous P0 write / P1 read after reset: P0 first, no bubble to P1
        add(1, 0,1,1,DB, 1,0,2,0, 0, 0,0,0,0,  2'b00, 1,1,0);
        add(0, 0,1,1,DB, 1,0,2,0, 0, 0,0,0,0,  2'b00, 1,1,0);
        add(0, 0,1,1,DB, 1,0,2,0, 1, 0,1,1,DB, 2'b01, 0,1,0);
        add(0, 0,0,0,0,  1,0,2,0, 0, 1,0,2,0,  2'b10, 0,1,0);
        add(0, 0,0,0,0,  1,0,2,0, 1, 1,0,2,0,  2'b10, 0,0,0);
        add(0, 0,0,0,0,  0,0,0,0, 0, 0,0,2,0,  2'b00, 0,0,0);

        // Both requesting, ack in first strobe cycle: alternating grants, 4 each
        add(0, 1,0,'h100,0, 0,1,'h200,W1, 0, 0,0,2,0, 2'b00, 1,1,0);
        for (int k = 1; k <= 7; k++) begin
            if (k % 2 == 1)
                add(0, 1,0,'h100,0, 0,1,'h200,W1, 1, 1,0,'h100,0,  2'b01, 0,1,0);
            else
                add(0, 1,0,'h100,0, 0,1,'h200,W1, 1, 0,1,'h200,W1, 2'b10, 1,0,0);
        end
        add(0, 0,0,0,0,     0,1,'h200,W1, 1, 0,1,'h200,W1, 2'b10, 0,0,0);
        add(0, 0,0,0,0,     0,0,0,0,      0, 0,0,'h200,W1, 2'b00, 0,0,0);

        // P1 rd+wr with inputs changing while granted: latched write command holds
        add(0, 0,0,0,0, 1,1,'h0AAAA,WA,           0, 0,0,'h200,W1,  2'b00, 0,1,0);
        add(0, 0,0,0,0, 1,1,'h15555,'h5A5A5A5A,   0, 0,1,'h0AAAA,WA, 2'b10, 0,1,0);
        add(0, 0,0,0,0, 1,0,'h1FFFF,'hFFFFFFFF,   0, 0,1,'h0AAAA,WA, 2'b10, 0,1,0);
        add(0, 0,0,0,0, 1,1,'h00001,'h12345678,   1, 0,1,'h0AAAA,WA, 2'b10, 0,0,0);
        add(0, 0,0,0,0, 0,0,0,0,                  0, 0,0,'h0AAAA,WA, 2'b00, 0,0,0);

        // Timeout after 4 BUSY cycles, ack in IDLE ignored, regrant, sticky flag
        add(0, 1,0,'h33,0, 0,0,0,0, 0, 0,0,'h0AAAA,WA, 2'b00, 1,0,0);
        for (int k = 0; k < 4; k++)
            add(0, 1,0,'h33,0, 0,0,0,0, 0, 1,0,'h33,0, 2'b01, 1,0,0);
        add(0, 1,0,'h33,0, 0,0,0,0, 1, 0,0,'h33,0, 2'b00, 1,0,1);
        add(0, 1,0,'h33,0, 0,0,0,0, 0, 1,0,'h33,0, 2'b01, 1,0,1);
        add(0, 1,0,'h33,0, 0,0,0,0, 1, 1,0,'h33,0, 2'b01, 0,0,1);
        add(0, 0,0,0,0,    0,0,0,0, 0, 0,0,'h33,0, 2'b00, 0,0,1);
        add(0, 0,0,0,0,    0,0,0,0, 1, 0,0,'h33,0, 2'b00, 0,0,1);

        // Reset clears the flag; reset during BUSY1 drops the command, then regrant
        add(1, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 2'b00, 0,0,0);
        add(0, 0,0,0,0, 1,0,7,0, 0, 0,0,0,0, 2'b00, 0,1,0);
        add(0, 0,0,0,0, 1,0,7,0, 0, 1,0,7,0, 2'b10, 0,1,0);
        add(1, 0,0,0,0, 1,0,7,0, 0, 0,0,0,0, 2'b00, 0,1,0);
        add(0, 0,0,0,0, 1,0,7,0, 0, 0,0,0,0, 2'b00, 0,1,0);
        add(0, 0,0,0,0, 1,0,7,0, 0, 1,0,7,0, 2'b10, 0,1,0);
        add(0, 0,0,0,0, 1,0,7,0, 1, 1,0,7,0, 2'b10, 0,0,0);
        add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,7,0, 2'b00, 0,0,0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // Same-port back-to-back: one IDLE cycle between, then async reset mid-transaction
        reset = 1'b0; p0_rd = 1'b1; p0_addr = 17'h00044; sram_ack = 1'b1;
        @(negedge clk);
        chk("b2b idle0 grant", 32'(grant), 32'h0);
        chk("b2b idle0 p0_stall", 32'(p0_stall), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b busy0 grant", 32'(grant), 32'h1);
        chk("b2b busy0 p0_stall", 32'(p0_stall), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b gap grant", 32'(grant), 32'h0);
        chk("b2b gap sram_re", 32'(sram_re), 32'h0);
        chk("b2b gap p0_stall", 32'(p0_stall), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b busy1 grant", 32'(grant), 32'h1);
        chk("b2b busy1 sram_addr", 32'(sram_addr), 32'h44);
        #1 reset = 1'b1;
        #1;
        chk("async rst sram_re", 32'(sram_re), 32'h0);
        chk("async rst grant", 32'(grant), 32'h0);
        chk("async rst sram_addr", 32'(sram_addr), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; p0_rd = 1'b0; sram_ack = 1'b0;
        @(negedge clk);
        chk("post rst grant", 32'(grant), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
